out_req_fifo: RTL and testbench

Downstream buffer for the communication assist's outbound request path. It accepts flits written by the OUT_req arbiter, one per cycle, and advertises free space through `OUT_req_rdy`. It holds flits in order and presents them to the ring network interface with a valid/ready handshake. Packet boundaries come from the 2-bit ctrl field; tail flit = `2'b11`.

---
 rtl/ring_pkg.sv | 27 ++
 rtl/out_req_fifo_if.sv | 35 +++
 rtl/sync_fifo_mem.sv | 39 +++
 rtl/out_req_fifo.sv | 150 +++++++++++++++
 tb/tb_out_req_fifo.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Shared definitions for the ring network request path: flit ctrl encodings,
// the default flit payload width, the packed flit type and a small ctrl
// decode helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ring_pkg;

    localparam int FLIT_W_DEFAULT = 16;

    localparam logic [1:0] FLIT_NONE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef struct packed {
        logic [1:0]                ctrl;
        logic [FLIT_W_DEFAULT-1:0] data;
    } flit_t;

    // True when the ctrl field marks the last flit of a packet.
    function automatic logic is_tail(input logic [1:0] ctrl);
        return (ctrl == FLIT_TAIL);
    endfunction

endpackage

// File: rtl/out_req_fifo_if.sv
// ---------------------------------------------------------------------------
// out_req_fifo_if
// Handshake bundle between the OUT_req arbiter / ring network interface
// (master side) and the outbound request FIFO (slave side).
// Signals:
//   wr_en, flit_in, ctrl_in   push side, driven by the arbiter
//   OUT_req_rdy               FIFO has at least one free entry
//   v_flit_out, flit_out,
//   ctrl_out                  head-of-queue flit presented to the network
//   net_rdy                   network accepts the presented flit
// ---------------------------------------------------------------------------
interface out_req_fifo_if
    import ring_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEFAULT
);
    logic              wr_en;
    logic [FLIT_W-1:0] flit_in;
    logic [1:0]        ctrl_in;
    logic              OUT_req_rdy;
    logic              v_flit_out;
    logic [FLIT_W-1:0] flit_out;
    logic [1:0]        ctrl_out;
    logic              net_rdy;

    modport master (
        output wr_en, flit_in, ctrl_in, net_rdy,
        input  OUT_req_rdy, v_flit_out, flit_out, ctrl_out
    );

    modport slave (
        input  wr_en, flit_in, ctrl_in, net_rdy,
        output OUT_req_rdy, v_flit_out, flit_out, ctrl_out
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x W register array with one synchronous write port and one
// combinational read port. Holds no control state; pointers live in the
// owning FIFO. Contents are not reset: they are only ever read under a
// valid indication derived from the owner's reset-cleared state.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int W     = 18,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/out_req_fifo.sv
// ---------------------------------------------------------------------------
// out_req_fifo
// Outbound request buffer between the OUT_req arbiter and the ring network
// interface. In-order circular FIFO with registered occupancy, ready and
// valid, and a sticky overflow flag.
// Configuration macro: OUT_REQ_STORE_FWD_EN
//   undefined : cut-through, a flit is offered as soon as it is stored
//   defined   : store-and-forward, flits are offered only while at least one
//               complete packet (tail stored) is held
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, discards all contents
//   bus      out_req_fifo_if.slave: wr_en/flit_in/ctrl_in push side,
//            OUT_req_rdy free-space flag, v_flit_out/flit_out/ctrl_out/
//            net_rdy network side
//   count    current occupancy, 0..DEPTH
//   err_ovf  sticky overflow flag, cleared only by rst
// ---------------------------------------------------------------------------
module out_req_fifo
    import ring_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEFAULT,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    out_req_fifo_if.slave bus,
    output logic [AW:0]   count,
    output logic          err_ovf
);

    localparam logic [AW:0]   CNT_FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO_C = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE_C  = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO_C = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE_C  = AW'(1'b1);

    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW:0]       count_r;
    logic              err_r;
    logic              rdy_r;
    logic              valid_r;

    logic              push_s;
    logic              pop_s;
    logic [AW:0]       count_nxt_s;
    logic              valid_nxt_s;
    logic              err_set_s;
    logic [FLIT_W+1:0] rdata_s;

`ifdef OUT_REQ_STORE_FWD_EN
    logic [AW:0]       pkt_cnt_r;
    logic [AW:0]       pkt_nxt_s;
    logic              tail_in_s;
    logic              tail_out_s;
`endif

    sync_fifo_mem #(
        .W     (FLIT_W + 2),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata ({bus.ctrl_in, bus.flit_in}),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Next-state decode: push/pop qualification, occupancy and flags.
    always_comb begin
        // Readiness is judged on the pre-pop count, so a full FIFO never
        // accepts a write even when a pop happens in the same cycle.
        push_s = bus.wr_en & (count_r != CNT_FULL_C);
        pop_s  = valid_r & bus.net_rdy;

        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase

        err_set_s = bus.wr_en & (count_r == CNT_FULL_C);

`ifdef OUT_REQ_STORE_FWD_EN
        tail_in_s  = push_s & is_tail(bus.ctrl_in);
        tail_out_s = pop_s & is_tail(rdata_s[FLIT_W+1:FLIT_W]);

        pkt_nxt_s = pkt_cnt_r;
        case ({tail_in_s, tail_out_s})
            2'b10:   pkt_nxt_s = pkt_cnt_r + CNT_ONE_C;
            2'b01:   pkt_nxt_s = pkt_cnt_r - CNT_ONE_C;
            default: pkt_nxt_s = pkt_cnt_r;
        endcase

        // A full FIFO with no complete packet can never drain: a packet
        // longer than DEPTH has been pushed.
        if ((count_nxt_s == CNT_FULL_C) && (pkt_nxt_s == CNT_ZERO_C)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end

        valid_nxt_s = (count_nxt_s != CNT_ZERO_C) & (pkt_nxt_s != CNT_ZERO_C);
`else
        valid_nxt_s = (count_nxt_s != CNT_ZERO_C);
`endif
    end

    // Pointer, occupancy and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r  <= PTR_ZERO_C;
            wr_ptr_r  <= PTR_ZERO_C;
            count_r   <= CNT_ZERO_C;
            err_r     <= 1'b0;
            rdy_r     <= 1'b1;
            valid_r   <= 1'b0;
`ifdef OUT_REQ_STORE_FWD_EN
            pkt_cnt_r <= CNT_ZERO_C;
`endif
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r   <= count_nxt_s;
            err_r     <= err_r | err_set_s;
            rdy_r     <= (count_nxt_s != CNT_FULL_C);
            valid_r   <= valid_nxt_s;
`ifdef OUT_REQ_STORE_FWD_EN
            pkt_cnt_r <= pkt_nxt_s;
`endif
        end
    end

    assign bus.OUT_req_rdy = rdy_r;
    assign bus.v_flit_out  = valid_r;
    assign bus.flit_out    = rdata_s[FLIT_W-1:0];
    assign bus.ctrl_out    = rdata_s[FLIT_W+1:FLIT_W];
    assign count           = count_r;
    assign err_ovf         = err_r;

endmodule

// File: tb/tb_out_req_fifo.sv
// ---------------------------------------------------------------------------
// tb_out_req_fifo
// Directed bench for out_req_fifo (DEPTH 8, FLIT_W 16). A negedge monitor
// keeps a reference queue of accepted flits plus occupancy / packet / error
// state and compares every output each cycle; the initial block drives the
// directed steps and checks the timing points of interest.
// Build with OUT_REQ_STORE_FWD_EN defined to exercise store-and-forward.
// ---------------------------------------------------------------------------
module tb_out_req_fifo;
    import ring_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic       err_ovf;

    out_req_fifo_if #(.FLIT_W(16)) bus_if();

    out_req_fifo #(.FLIT_W(16), .DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .count   (count),
        .err_ovf (err_ovf)
    );

    always #5 clk = ~clk;

`ifdef OUT_REQ_STORE_FWD_EN
    localparam logic [1:0] FILL_CTRL = FLIT_TAIL;
`else
    localparam logic [1:0] FILL_CTRL = FLIT_BODY;
`endif

    int    n_tests = 0;
    int    n_fail  = 0;
    flit_t exp_q[$];
    int    m_count = 0;
    int    m_pkt   = 0;
    bit    m_err   = 1'b0;
    bit    m_ok    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] c, input logic [15:0] d, input logic nr);
        bus_if.wr_en   = we;
        bus_if.ctrl_in = c;
        bus_if.flit_in = d;
        bus_if.net_rdy = nr;
    endtask

    // Reference model: compare outputs, then advance to the state the next
    // posedge will produce from the inputs currently applied.
    always @(negedge clk) begin
        bit exp_v;
        bit push_m;
        bit pop_m;
        flit_t f;
        if (m_ok) begin
            exp_v = (m_count != 0);
`ifdef OUT_REQ_STORE_FWD_EN
            exp_v = exp_v && (m_pkt != 0);
`endif
            check("mon_valid", 32'(bus_if.v_flit_out), 32'(exp_v));
            check("mon_rdy", 32'(bus_if.OUT_req_rdy), 32'(m_count != 8));
            check("mon_count", 32'(count), 32'(m_count));
            check("mon_err", 32'(err_ovf), 32'(m_err));
            if (exp_v) begin
                check("mon_data", 32'({bus_if.ctrl_out, bus_if.flit_out}), 32'(exp_q[0]));
            end
            if (!rst) begin
                push_m = bus_if.wr_en && (m_count != 8);
                pop_m  = exp_v && bus_if.net_rdy;
                if (bus_if.wr_en && (m_count == 8)) m_err = 1'b1;
                if (pop_m) begin
                    f = exp_q.pop_front();
                    if (f.ctrl == FLIT_TAIL) m_pkt--;
                    m_count--;
                end
                if (push_m) begin
                    f.ctrl = bus_if.ctrl_in;
                    f.data = bus_if.flit_in;
                    exp_q.push_back(f);
                    if (f.ctrl == FLIT_TAIL) m_pkt++;
                    m_count++;
                end
`ifdef OUT_REQ_STORE_FWD_EN
                if ((m_count == 8) && (m_pkt == 0)) m_err = 1'b1;
`endif
            end
        end
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_pkt   = 0;
            m_err   = 1'b0;
            m_ok    = 1'b1;
        end
    end

    initial begin
        logic [1:0] c;
        int sent;
        rst = 1'b1;
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_rdy", 32'(bus_if.OUT_req_rdy), 32'd1);
        check("rst_valid", 32'(bus_if.v_flit_out), 32'd0);
        check("rst_err", 32'(err_ovf), 32'd0);

        // 1: three-flit packet with the network always ready
        drive(1'b1, FLIT_HEAD, 16'h1111, 1'b1);
        tick();
`ifdef OUT_REQ_STORE_FWD_EN
        check("t1_valid_head", 32'(bus_if.v_flit_out), 32'd0);
`else
        check("t1_valid_head", 32'(bus_if.v_flit_out), 32'd1);
`endif
        drive(1'b1, FLIT_BODY, 16'h2222, 1'b1);
        tick();
`ifdef OUT_REQ_STORE_FWD_EN
        check("t1_valid_body", 32'(bus_if.v_flit_out), 32'd0);
`else
        check("t1_valid_body", 32'(bus_if.v_flit_out), 32'd1);
`endif
        drive(1'b1, FLIT_TAIL, 16'h3333, 1'b1);
        tick();
        check("t1_valid_tail", 32'(bus_if.v_flit_out), 32'd1);
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b1);
        for (int i = 0; i < 20 && count != 4'd0; i++) tick();
        check("t1_drained", 32'(count), 32'd0);

        // 2: fill with the network stalled, then overflow
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, FILL_CTRL, 16'hB000 + 16'(i), 1'b0);
            tick();
        end
        check("t2_full_count", 32'(count), 32'd8);
        check("t2_full_rdy", 32'(bus_if.OUT_req_rdy), 32'd0);
        check("t2_full_err", 32'(err_ovf), 32'd0);
        drive(1'b1, FILL_CTRL, 16'hBEEF, 1'b0);
        tick();
        check("t2_ovf_count", 32'(count), 32'd8);
        check("t2_ovf_err", 32'(err_ovf), 32'd1);

        // 3: push+pop while full, then push+pop at count 4
        drive(1'b1, FILL_CTRL, 16'hDEAD, 1'b1);
        tick();
        check("t3_full_pp_count", 32'(count), 32'd7);
        check("t3_full_pp_err", 32'(err_ovf), 32'd1);
        check("t3_rdy_back", 32'(bus_if.OUT_req_rdy), 32'd1);
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b1);
        tick();
        tick();
        tick();
        check("t3_count4", 32'(count), 32'd4);
        drive(1'b1, FILL_CTRL, 16'hC000, 1'b1);
        tick();
        check("t3_pp_count", 32'(count), 32'd4);
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b1);
        for (int i = 0; i < 20 && count != 4'd0; i++) tick();
        check("t3_drained", 32'(count), 32'd0);

        // 6: reset with five flits queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, FILL_CTRL, 16'hE000 + 16'(i), 1'b0);
            tick();
        end
        check("t6_queued", 32'(count), 32'd5);
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count", 32'(count), 32'd0);
        check("t6_valid", 32'(bus_if.v_flit_out), 32'd0);
        check("t6_rdy", 32'(bus_if.OUT_req_rdy), 32'd1);
        check("t6_err", 32'(err_ovf), 32'd0);

        // 4: 20 flits in 4-flit packets with random network stalls
        sent = 0;
        for (int cyc = 0; cyc < 400 && sent < 20; cyc++) begin
            if ((sent % 4) == 0)      c = FLIT_HEAD;
            else if ((sent % 4) == 3) c = FLIT_TAIL;
            else                      c = FLIT_BODY;
            if (bus_if.OUT_req_rdy) begin
                drive(1'b1, c, 16'hA000 + 16'(sent), 1'($urandom_range(0, 1)));
                sent++;
            end else begin
                drive(1'b0, FLIT_NONE, 16'h0000, 1'($urandom_range(0, 1)));
            end
            tick();
        end
        check("t4_sent", 32'(sent), 32'd20);
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b1);
        for (int i = 0; i < 40 && count != 4'd0; i++) tick();
        check("t4_drained", 32'(count), 32'd0);
        check("t4_err", 32'(err_ovf), 32'd0);

`ifdef OUT_REQ_STORE_FWD_EN
        // 5: held tail keeps the packet back, then it drains back-to-back
        drive(1'b1, FLIT_HEAD, 16'h5001, 1'b1);
        tick();
        check("t5_v_head", 32'(bus_if.v_flit_out), 32'd0);
        drive(1'b1, FLIT_BODY, 16'h5002, 1'b1);
        tick();
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t5_v_hold", 32'(bus_if.v_flit_out), 32'd0);
            tick();
        end
        check("t5_hold_count", 32'(count), 32'd2);
        drive(1'b1, FLIT_TAIL, 16'h5003, 1'b1);
        tick();
        drive(1'b0, FLIT_NONE, 16'h0000, 1'b1);
        check("t5_v1", 32'(bus_if.v_flit_out), 32'd1);
        tick();
        check("t5_v2", 32'(bus_if.v_flit_out), 32'd1);
        tick();
        check("t5_v3", 32'(bus_if.v_flit_out), 32'd1);
        tick();
        check("t5_v_end", 32'(bus_if.v_flit_out), 32'd0);
        check("t5_count_end", 32'(count), 32'd0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
